s_axil_regbank: RTL and testbench



---
 rtl/s_axil_regbank_pkg.sv | 34 +++
 rtl/s_axil_regbank_wr.sv | 101 ++++++++++
 rtl/s_axil_regbank.sv | 169 ++++++++++++++++
 tb/tb_s_axil_regbank.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_axil_regbank_pkg.sv
// s_axil_regbank_pkg
// Shared definitions for the AXI4-Lite register bank: response codes,
// the word-index LSB helper and the address-region decode.
// No ports (package).

package s_axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_STAT,
        REG_NONE
    } region_e;

    // Byte-address bits below the word index.
    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Map a word index onto the control, status or unmapped region.
    function automatic region_e decode_region(input int unsigned idx,
                                              input int unsigned n_ctrl,
                                              input int unsigned n_stat);
        if (idx < n_ctrl) begin
            return REG_CTRL;
        end else if (idx < n_ctrl + n_stat) begin
            return REG_STAT;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/s_axil_regbank_wr.sv
// s_axil_regbank_wr
// Write side of the register bank: independent AW and W holding registers,
// the commit decision and the B channel.
// Ports:
//   axi_clock, rst_n            clock, synchronous active-low reset
//   s_axil_aw*/s_axil_w*/s_axil_b*  AXI4-Lite write channels
//   commit                      high in the cycle a held AW/W pair retires
//   commit_region/commit_idx    decoded target of the retiring write
//   commit_data/commit_mask     write data already masked by wstrb, and the
//                               bit mask of the lanes to update

module s_axil_regbank_wr
    import s_axil_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int N_CTRL     = 8,
    parameter int N_STAT     = 4,
    localparam int LSB       = word_lsb(DATA_WIDTH),
    localparam int IDX_W     = ADDR_WIDTH - LSB
) (
    input  logic                    axi_clock,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic                    commit,
    output region_e                 commit_region,
    output logic [IDX_W-1:0]        commit_idx,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH-1:0]   commit_mask
);

    logic                    aw_full;
    logic                    w_full;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    assign s_axil_awready = !aw_full;
    assign s_axil_wready  = !w_full;

    // A pair retires only when the B slot is free or being drained this cycle,
    // so a stalled response blocks at most one further AW and one further W.
    assign commit        = aw_full && w_full && (!s_axil_bvalid || s_axil_bready);
    assign commit_idx    = aw_addr[ADDR_WIDTH-1:LSB];
    assign commit_region = decode_region(32'(commit_idx), N_CTRL, N_STAT);

    for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_lane
        assign commit_mask[i*8 +: 8] = {8{w_strb[i]}};
    end
    assign commit_data = w_data & commit_mask;

    always_ff @(posedge axi_clock) begin
        if (!rst_n) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            // commit implies both holds are full, so no capture can coincide
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (s_axil_awvalid) aw_full <= 1'b1;
                if (s_axil_wvalid)  w_full  <= 1'b1;
            end

            if (commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= (commit_region == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Holding payloads need no reset: they are qualified by aw_full/w_full.
    always_ff @(posedge axi_clock) begin
        if (s_axil_awvalid && s_axil_awready) begin
            aw_addr <= s_axil_awaddr;
        end
        if (s_axil_wvalid && s_axil_wready) begin
            w_data <= s_axil_wdata;
            w_strb <= s_axil_wstrb;
        end
    end

    logic unused;
    assign unused = &{1'b0, s_axil_awprot, aw_addr};

endmodule

// File: rtl/s_axil_regbank.sv
// s_axil_regbank
// AXI4-Lite slave register bank: N_CTRL read/write control registers with
// reset image CTRL_RST, N_STAT read-only status registers from the fabric,
// SLVERR on illegal accesses and a one-cycle write strobe per control register.
// Optional feature macro: REGBANK_RD_PULSE_EN adds rd_pulse, a one-cycle
// strobe per status register read (aligned with the rvalid rise).
// Ports:
//   axi_clock, rst_n            clock, synchronous active-low reset
//   s_axil_aw*/w*/b*/ar*/r*     AXI4-Lite slave channels
//   ctrl_regs                   flat control register contents
//   wr_pulse                    bit k pulses after a commit to control reg k
//   stat_regs                   flat status inputs, same packing as ctrl_regs
//   rd_pulse                    (REGBANK_RD_PULSE_EN only) status read strobes

module s_axil_regbank
    import s_axil_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int N_CTRL     = 8,
    parameter int N_STAT     = 4,
    parameter logic [N_CTRL*DATA_WIDTH-1:0] CTRL_RST = '0
) (
    input  logic                         axi_clock,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [DATA_WIDTH-1:0]        s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [DATA_WIDTH-1:0]        s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_regs,
    output logic [N_CTRL-1:0]            wr_pulse,
    input  logic [N_STAT*DATA_WIDTH-1:0] stat_regs
`ifdef REGBANK_RD_PULSE_EN
    ,
    output logic [N_STAT-1:0]            rd_pulse
`endif
);

    localparam int LSB   = word_lsb(DATA_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - LSB;

    logic                  commit;
    region_e               commit_region;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [DATA_WIDTH-1:0] commit_mask;

    s_axil_regbank_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_CTRL     (N_CTRL),
        .N_STAT     (N_STAT)
    ) u_wr (
        .axi_clock      (axi_clock),
        .rst_n          (rst_n),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .commit         (commit),
        .commit_region  (commit_region),
        .commit_idx     (commit_idx),
        .commit_data    (commit_data),
        .commit_mask    (commit_mask)
    );

    logic [DATA_WIDTH-1:0] ctrl_q [N_CTRL];

    always_ff @(posedge axi_clock) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= CTRL_RST[k*DATA_WIDTH +: DATA_WIDTH];
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && commit_region == REG_CTRL) begin
                for (int k = 0; k < N_CTRL; k++) begin
                    if (commit_idx == IDX_W'(k)) begin
                        ctrl_q[k]   <= (ctrl_q[k] & ~commit_mask) | commit_data;
                        // strobes even for an all-zero wstrb
                        wr_pulse[k] <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end

    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    region_e               ar_region;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign s_axil_arready = !s_axil_rvalid || s_axil_rready;
    assign ar_hs          = s_axil_arvalid && s_axil_arready;
    assign ar_idx         = s_axil_araddr[ADDR_WIDTH-1:LSB];
    assign ar_region      = decode_region(32'(ar_idx), N_CTRL, N_STAT);

    // Unmapped indices fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            if (ar_idx == IDX_W'(k)) rd_mux = ctrl_q[k];
        end
        for (int j = 0; j < N_STAT; j++) begin
            if (ar_idx == IDX_W'(N_CTRL + j)) rd_mux = stat_regs[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // rdata samples ctrl_q before any same-cycle commit lands: old value wins.
    always_ff @(posedge axi_clock) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_mux;
            s_axil_rresp  <= (ar_region == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

`ifdef REGBANK_RD_PULSE_EN
    always_ff @(posedge axi_clock) begin
        if (!rst_n) begin
            rd_pulse <= '0;
        end else begin
            rd_pulse <= '0;
            if (ar_hs && ar_region == REG_STAT) begin
                for (int j = 0; j < N_STAT; j++) begin
                    if (ar_idx == IDX_W'(N_CTRL + j)) rd_pulse[j] <= 1'b1;
                end
            end
        end
    end
`endif

    logic unused;
    assign unused = &{1'b0, s_axil_arprot, s_axil_araddr};

endmodule

// File: tb/tb_s_axil_regbank.sv
// tb_s_axil_regbank
// Directed bench for s_axil_regbank with a transaction-level register model
// and a per-cycle compare process; directed literal checks pin the model.
// Honours REGBANK_RD_PULSE_EN when defined for the build.

`timescale 1ns/1ps

module tb_s_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NC = 8;
    localparam int NS = 4;
    localparam logic [NC*DW-1:0] RST_IMG = 256'h0000_00FF << 32;

    logic              axi_clock = 1'b0;
    logic              rst_n     = 1'b0;
    logic [AW-1:0]     s_axil_awaddr  = '0;
    logic [2:0]        s_axil_awprot  = '0;
    logic              s_axil_awvalid = 1'b0;
    logic              s_axil_awready;
    logic [DW-1:0]     s_axil_wdata   = '0;
    logic [DW/8-1:0]   s_axil_wstrb   = '0;
    logic              s_axil_wvalid  = 1'b0;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready  = 1'b1;
    logic [AW-1:0]     s_axil_araddr  = '0;
    logic [2:0]        s_axil_arprot  = '0;
    logic              s_axil_arvalid = 1'b0;
    logic              s_axil_arready;
    logic [DW-1:0]     s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready  = 1'b1;
    logic [NC*DW-1:0]  ctrl_regs;
    logic [NC-1:0]     wr_pulse;
    logic [NS*DW-1:0]  stat_regs      = '0;
`ifdef REGBANK_RD_PULSE_EN
    logic [NS-1:0]     rd_pulse;
    int                rp0_cnt = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit done_aw = 1'b0;
    bit done_w  = 1'b0;

    s_axil_regbank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N_CTRL     (NC),
        .N_STAT     (NS),
        .CTRL_RST   (RST_IMG)
    ) dut (
        .axi_clock      (axi_clock),
        .rst_n          (rst_n),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .ctrl_regs      (ctrl_regs),
        .wr_pulse       (wr_pulse),
        .stat_regs      (stat_regs)
`ifdef REGBANK_RD_PULSE_EN
        ,
        .rd_pulse       (rd_pulse)
`endif
    );

    always #5 axi_clock = ~axi_clock;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]   m_ctrl [NC];
    logic [AW-1:0]   q_aw [$];
    logic [DW-1:0]   q_wd [$];
    logic [DW/8-1:0] q_ws [$];
    logic [DW-1:0]   q_rd [$];
    logic [1:0]      q_rr [$];
    int              q_rs [$];
    logic [1:0]      m_bresp = 2'b00;
    bit prev_bv = 0, prev_bhs = 0, prev_rv = 0, prev_rhs = 0;

    always @(negedge axi_clock) begin
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        logic [DW/8-1:0]  s;
        logic [NC*DW-1:0] flat;
        logic [NC-1:0]    exp_wp;
        logic [NS-1:0]    exp_rp;
        int               idx;
        int               rs;
        if (!rst_n) begin
            for (int k = 0; k < NC; k++) m_ctrl[k] = RST_IMG[k*DW +: DW];
            q_aw.delete(); q_wd.delete(); q_ws.delete();
            q_rd.delete(); q_rr.delete(); q_rs.delete();
            prev_bv = 0; prev_bhs = 0; prev_rv = 0; prev_rhs = 0;
        end else begin
            exp_wp = '0;
            exp_rp = '0;
            // a fresh B beat means one write has taken effect
            if (s_axil_bvalid && (!prev_bv || prev_bhs)) begin
                chk("b_has_pair", 32'(q_aw.size() > 0 && q_wd.size() > 0), 1);
                if (q_aw.size() > 0 && q_wd.size() > 0) begin
                    a = q_aw.pop_front();
                    d = q_wd.pop_front();
                    s = q_ws.pop_front();
                    idx = int'(a[AW-1:2]);
                    if (idx < NC) begin
                        for (int i = 0; i < DW/8; i++)
                            if (s[i]) m_ctrl[idx][8*i +: 8] = d[8*i +: 8];
                        exp_wp[idx] = 1'b1;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
            end
            if (s_axil_bvalid) chk("bresp", s_axil_bresp, m_bresp);
            chk("wr_pulse", wr_pulse, exp_wp);
            for (int k = 0; k < NC; k++) flat[k*DW +: DW] = m_ctrl[k];
            chk("ctrl_regs", ctrl_regs, flat);

            if (s_axil_rvalid && (!prev_rv || prev_rhs)) begin
                chk("r_expected", 32'(q_rd.size()), 32'(q_rd.size() > 0 ? q_rd.size() : 1));
                if (q_rd.size() > 0) begin
                    chk("rdata", s_axil_rdata, q_rd.pop_front());
                    chk("rresp", s_axil_rresp, q_rr.pop_front());
                    rs = q_rs.pop_front();
                    if (rs >= 0) exp_rp[rs] = 1'b1;
                end
            end
`ifdef REGBANK_RD_PULSE_EN
            chk("rd_pulse", rd_pulse, exp_rp);
`endif
            // handshakes that complete at the coming edge
            if (s_axil_awvalid && s_axil_awready) q_aw.push_back(s_axil_awaddr);
            if (s_axil_wvalid && s_axil_wready) begin
                q_wd.push_back(s_axil_wdata);
                q_ws.push_back(s_axil_wstrb);
            end
            if (s_axil_arvalid && s_axil_arready) begin
                idx = int'(s_axil_araddr[AW-1:2]);
                if (idx < NC) begin
                    q_rd.push_back(m_ctrl[idx]); q_rr.push_back(2'b00); q_rs.push_back(-1);
                end else if (idx < NC + NS) begin
                    q_rd.push_back(stat_regs[(idx-NC)*DW +: DW]); q_rr.push_back(2'b00); q_rs.push_back(idx - NC);
                end else begin
                    q_rd.push_back('0); q_rr.push_back(2'b10); q_rs.push_back(-1);
                end
            end
            prev_bv  = s_axil_bvalid;
            prev_bhs = s_axil_bvalid && s_axil_bready;
            prev_rv  = s_axil_rvalid;
            prev_rhs = s_axil_rvalid && s_axil_rready;
        end
    end

`ifdef REGBANK_RD_PULSE_EN
    always @(negedge axi_clock) if (rst_n && rd_pulse[0]) rp0_cnt++;
`endif

    // ---------------- drivers ----------------
    task automatic aw_send(input logic [AW-1:0] a);
        bit hs = 1'b0;
        s_axil_awaddr  = a;
        s_axil_awvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge axi_clock); hs = s_axil_awready;
            @(posedge axi_clock); #1;
        end
        s_axil_awvalid = 1'b0;
        chk("aw_handshake", 32'(hs), 1);
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        bit hs = 1'b0;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_wvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge axi_clock); hs = s_axil_wready;
            @(posedge axi_clock); #1;
        end
        s_axil_wvalid = 1'b0;
        chk("w_handshake", 32'(hs), 1);
    endtask

    task automatic ar_send(input logic [AW-1:0] a);
        bit hs = 1'b0;
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge axi_clock); hs = s_axil_arready;
            @(posedge axi_clock); #1;
        end
        s_axil_arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge axi_clock); #1; end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tick(3);
        @(negedge axi_clock);
        chk("rst_awready", s_axil_awready, 1);
        chk("rst_wready",  s_axil_wready, 1);
        chk("rst_arready", s_axil_arready, 1);
        chk("rst_bvalid",  s_axil_bvalid, 0);
        chk("rst_rvalid",  s_axil_rvalid, 0);
        chk("rst_rdata",   s_axil_rdata, 0);
        chk("rst_reg1",    ctrl_regs[1*DW +: DW], 32'h0000_00FF);
        chk("rst_reg0",    ctrl_regs[0*DW +: DW], 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        @(posedge axi_clock); #1 rst_n = 1'b1;
        tick(1);

        // simultaneous AW/W, partial strobe
        fork
            aw_send(12'h004);
            w_send(32'hDEAD_BEEF, 4'b0101);
        join
        @(negedge axi_clock);
        chk("t1_reg1_unchanged", ctrl_regs[1*DW +: DW], 32'h0000_00FF);
        chk("t1_bvalid", s_axil_bvalid, 0);
        @(negedge axi_clock);
        chk("t2_reg1", ctrl_regs[1*DW +: DW], 32'h00AD_00EF);
        chk("t2_wr_pulse", wr_pulse, 8'h02);
        chk("t2_bvalid", s_axil_bvalid, 1);
        chk("t2_bresp", s_axil_bresp, 2'b00);
        @(negedge axi_clock);
        chk("t3_wr_pulse", wr_pulse, 8'h00);
        tick(1);

        // W well ahead of AW
        w_send(32'h1234_5678, 4'hF);
        tick(2);
        aw_send(12'h008);
        @(negedge axi_clock);
        chk("w_first_reg2_before", ctrl_regs[2*DW +: DW], 0);
        @(negedge axi_clock);
        chk("w_first_reg2", ctrl_regs[2*DW +: DW], 32'h1234_5678);
        chk("w_first_pulse", wr_pulse, 8'h04);
        tick(1);

        // write to status index, read of unmapped index, read of reg1
        fork
            aw_send(12'h020);
            w_send(32'hCAFE_F00D, 4'hF);
        join
        @(negedge axi_clock);
        @(negedge axi_clock);
        chk("stat_wr_bresp", s_axil_bresp, 2'b10);
        chk("stat_wr_pulse", wr_pulse, 0);
        chk("stat_wr_reg1", ctrl_regs[1*DW +: DW], 32'h00AD_00EF);
        tick(1);
        ar_send(12'hFFC);
        @(negedge axi_clock);
        chk("oor_rvalid", s_axil_rvalid, 1);
        chk("oor_rdata", s_axil_rdata, 0);
        chk("oor_rresp", s_axil_rresp, 2'b10);
        tick(1);
        ar_send(12'h004);
        @(negedge axi_clock);
        chk("rd_reg1", s_axil_rdata, 32'h00AD_00EF);
        chk("rd_reg1_resp", s_axil_rresp, 2'b00);
        tick(1);

        // read in the commit cycle returns the old value
        fork
            aw_send(12'h004);
            w_send(32'h0000_0000, 4'hF);
        join
        ar_send(12'h004);
        @(negedge axi_clock);
        chk("rd_old_value", s_axil_rdata, 32'h00AD_00EF);
        chk("rd_old_reg1_now", ctrl_regs[1*DW +: DW], 0);
        tick(1);

        // back-pressure on B
        s_axil_bready = 1'b0;
        fork
            aw_send(12'h00C);
            w_send(32'h1111_1111, 4'hF);
        join
        tick(2);
        fork
            begin aw_send(12'h00C); aw_send(12'h010); done_aw = 1'b1; end
            begin w_send(32'h2222_2222, 4'b0011); w_send(32'h3333_3333, 4'hF); done_w = 1'b1; end
        join_none
        tick(6);
        @(negedge axi_clock);
        chk("bp_awready", s_axil_awready, 0);
        chk("bp_wready", s_axil_wready, 0);
        chk("bp_bvalid", s_axil_bvalid, 1);
        chk("bp_reg3", ctrl_regs[3*DW +: DW], 32'h1111_1111);
        chk("bp_reg4", ctrl_regs[4*DW +: DW], 0);
        @(posedge axi_clock); #1 s_axil_bready = 1'b1;
        for (int n = 0; n < 60 && !(done_aw && done_w); n++) tick(1);
        chk("bp_drained", 32'(done_aw && done_w), 1);
        tick(4);
        @(negedge axi_clock);
        chk("bp_reg3_final", ctrl_regs[3*DW +: DW], 32'h1111_2222);
        chk("bp_reg4_final", ctrl_regs[4*DW +: DW], 32'h3333_3333);
        tick(1);

        // back-to-back reads with rready held high
        fork
            aw_send(12'h000);
            w_send(32'h0BAD_C0DE, 4'hF);
        join
        stat_regs[0 +: DW] = 32'hA5A5_0001;
        tick(3);
        s_axil_arvalid = 1'b1; s_axil_araddr = 12'h020;
        @(negedge axi_clock);
        chk("b2b_arready0", s_axil_arready, 1);
        @(posedge axi_clock); #1 s_axil_araddr = 12'h000;
        @(negedge axi_clock);
        chk("b2b_rvalid1", s_axil_rvalid, 1);
        chk("b2b_rdata1", s_axil_rdata, 32'hA5A5_0001);
        chk("b2b_arready1", s_axil_arready, 1);
        @(posedge axi_clock); #1 s_axil_araddr = 12'h020; stat_regs[0 +: DW] = 32'hA5A5_0002;
        @(negedge axi_clock);
        chk("b2b_rvalid2", s_axil_rvalid, 1);
        chk("b2b_rdata2", s_axil_rdata, 32'h0BAD_C0DE);
        @(posedge axi_clock); #1 s_axil_arvalid = 1'b0;
        @(negedge axi_clock);
        chk("b2b_rvalid3", s_axil_rvalid, 1);
        chk("b2b_rdata3", s_axil_rdata, 32'hA5A5_0002);
        tick(1);
        @(negedge axi_clock);
        chk("b2b_rvalid_idle", s_axil_rvalid, 0);
`ifdef REGBANK_RD_PULSE_EN
        chk("rd_pulse0_count", rp0_cnt, 2);
`endif
        tick(1);

        // reset with a held AW discards it
        aw_send(12'h008);
        @(negedge axi_clock);
        chk("held_aw_awready", s_axil_awready, 0);
        @(posedge axi_clock); #1 rst_n = 1'b0;
        @(posedge axi_clock); #1 rst_n = 1'b1;
        @(negedge axi_clock);
        chk("mid_rst_awready", s_axil_awready, 1);
        chk("mid_rst_reg2", ctrl_regs[2*DW +: DW], 0);
        chk("mid_rst_reg1", ctrl_regs[1*DW +: DW], 32'h0000_00FF);
        chk("mid_rst_bvalid", s_axil_bvalid, 0);
        tick(1);
        w_send(32'h9999_9999, 4'hF);
        tick(4);
        @(negedge axi_clock);
        chk("no_commit_bvalid", s_axil_bvalid, 0);
        chk("no_commit_reg2", ctrl_regs[2*DW +: DW], 0);
        chk("w_held_wready", s_axil_wready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
